// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drains bytes from the 8-deep byte FIFO (registered read
//                port) and serializes each one as an asynchronous UART frame:
//                start bit, 8 data bits LSB first, optional even parity,
//                1 or 2 stop bits. Idle line is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] byte_cnt
);

  // Bit timer width; CLKS_PER_BIT >= 2 so this is at least one bit.
  localparam int              c_tw        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_tw-1:0] c_tmax      = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_stop_last = 3'(STOP_BITS - 1);
  localparam logic            c_par_en    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_tw-1:0] r_timer;
  logic [c_tw-1:0] w_timer_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_parity;
  logic            w_parity_nxt;
  logic            r_tx;
  logic            w_tx_nxt;
  logic [15:0]     r_byte_cnt;
  logic            w_bit_end;
  logic            w_frame_end;
  logic            w_can_fetch;

  // The bit timer is the only source of bit boundaries.
  assign w_bit_end   = (r_timer == c_tmax);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_idx == c_stop_last);
  assign w_can_fetch = enable && !fifo_empty;

  // Moore outputs decoded from the state register; tx comes from its own flop.
  assign fifo_rd  = (r_state == S_FETCH);
  assign busy     = (r_state != S_IDLE);
  assign tx_done  = w_frame_end;
  assign tx       = r_tx;
  assign byte_cnt = r_byte_cnt;

  // Next-state, datapath next values and the next line level.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = '0;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_tx_nxt      = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_can_fetch) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // FIFO data is valid this cycle, one cycle after the read strobe.
        w_shift_nxt   = fifo_data;
        w_parity_nxt  = ^fifo_data;
        w_bit_idx_nxt = 3'd0;
        w_state_nxt   = S_START;
      end
      S_START: begin
        w_timer_nxt = w_bit_end ? '0 : r_timer + c_tw'(1);
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_timer_nxt = w_bit_end ? '0 : r_timer + c_tw'(1);
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = c_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        w_timer_nxt = w_bit_end ? '0 : r_timer + c_tw'(1);
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // r_bit_idx is reused here to count stop bits.
        w_timer_nxt = w_bit_end ? '0 : r_timer + c_tw'(1);
        if (w_bit_end) begin
          if (r_bit_idx == c_stop_last) begin
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = w_can_fetch ? S_FETCH : S_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level for the cycle that follows, so tx can be registered.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and frame counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_byte_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_tx      <= w_tx_nxt;
      if (w_frame_end) r_byte_cnt <= r_byte_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Directed self-checking bench for fifo_uart_tx. Instance 0 is
//                4 clk/bit, no parity, 1 stop; instance 1 is 4 clk/bit, even
//                parity, 2 stops. Each has a small registered-read FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int c_cpb = 4;

  logic        clk;
  logic        rst;
  logic        en0, en1;
  logic        empty0, empty1;
  logic [7:0]  data0, data1;
  logic        rd0, rd1;
  logic        tx0, tx1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [15:0] cnt0, cnt1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt [0:1];

  // FIFO models: registered read port, data valid the cycle after rd.
  logic [7:0]  mem0 [0:15];
  logic [7:0]  mem1 [0:15];
  logic [3:0]  wp0 = 4'd0, rp0 = 4'd0, wp1 = 4'd0, rp1 = 4'd0;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  fifo_uart_tx #(.CLKS_PER_BIT(c_cpb), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .fifo_empty(empty0), .fifo_data(data0),
    .fifo_rd(rd0), .tx(tx0), .busy(busy0), .tx_done(done0), .byte_cnt(cnt0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(c_cpb), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1), .fifo_data(data1),
    .fifo_rd(rd1), .tx(tx1), .busy(busy1), .tx_done(done1), .byte_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read side for both instances.
  always @(posedge clk) begin
    if (rd0) begin
      data0 <= mem0[rp0];
      rp0   <= rp0 + 4'd1;
    end
    if (rd1) begin
      data1 <= mem1[rp1];
      rp1   <= rp1 + 4'd1;
    end
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 1) begin
      mem1[wp1] = b;
      wp1 = wp1 + 4'd1;
    end else begin
      mem0[wp0] = b;
      wp0 = wp0 + 4'd1;
    end
  endtask

  function automatic logic s_tx(input int sel);   return (sel == 1) ? tx1 : tx0;     endfunction
  function automatic logic s_rd(input int sel);   return (sel == 1) ? rd1 : rd0;     endfunction
  function automatic logic s_busy(input int sel); return (sel == 1) ? busy1 : busy0; endfunction
  function automatic logic s_done(input int sel); return (sel == 1) ? done1 : done0; endfunction
  function automatic logic [15:0] s_cnt(input int sel); return (sel == 1) ? cnt1 : cnt0; endfunction

  // Expects FETCH at the next negedge, then LOAD, then the full frame.
  task automatic send_check(input int sel, input logic [7:0] b, input int drop_k);
    logic exp_tx [0:63];
    int   n;
    int   busy_cyc;
    int   stops;
    n        = 0;
    busy_cyc = 0;
    stops    = (sel == 1) ? 2 : 1;
    for (int i = 0; i < c_cpb; i++) begin exp_tx[n] = 1'b0; n++; end
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < c_cpb; i++) begin exp_tx[n] = b[j]; n++; end
    if (sel == 1)
      for (int i = 0; i < c_cpb; i++) begin exp_tx[n] = ^b; n++; end
    for (int i = 0; i < c_cpb * stops; i++) begin exp_tx[n] = 1'b1; n++; end

    @(negedge clk);
    check("fetch_rd", s_rd(sel), 1'b1);
    check("fetch_tx", s_tx(sel), 1'b1);
    if (s_busy(sel)) busy_cyc++;
    @(negedge clk);
    check("load_rd", s_rd(sel), 1'b0);
    check("load_tx", s_tx(sel), 1'b1);
    if (s_busy(sel)) busy_cyc++;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("frame_tx", s_tx(sel), exp_tx[k]);
      check("frame_done", s_done(sel), (k == n - 1));
      check("frame_rd", s_rd(sel), 1'b0);
      if (s_busy(sel)) busy_cyc++;
      if (k == drop_k) begin
        if (sel == 1) en1 = 1'b0; else en0 = 1'b0;
      end
    end
    check("busy_cycles", 16'(busy_cyc), 16'(n + 2));
    exp_cnt[sel] = exp_cnt[sel] + 16'd1;
  endtask

  task automatic idle_check(input int sel);
    @(negedge clk);
    check("idle_busy", s_busy(sel), 1'b0);
    check("idle_tx", s_tx(sel), 1'b1);
    check("idle_rd", s_rd(sel), 1'b0);
    check("idle_cnt", s_cnt(sel), exp_cnt[sel]);
  endtask

  task automatic quiet_cycles(input int sel, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("quiet_rd", s_rd(sel), 1'b0);
      check("quiet_tx", s_tx(sel), 1'b1);
      check("quiet_busy", s_busy(sel), 1'b0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    en0        = 1'b0;
    en1        = 1'b0;
    data0      = 8'h00;
    data1      = 8'h00;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;

    // Reset state
    @(negedge clk);
    check("rst_tx0", tx0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_rd0", rd0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_cnt0", cnt0, 16'h0000);
    check("rst_tx1", tx1, 1'b1);
    check("rst_cnt1", cnt1, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5
    push(0, 8'hA5);
    en0 = 1'b1;
    send_check(0, 8'hA5, -1);
    idle_check(0);

    // Back-to-back 0x00, 0xFF: FETCH must follow the last stop cycle directly
    push(0, 8'h00);
    push(0, 8'hFF);
    send_check(0, 8'h00, -1);
    send_check(0, 8'hFF, -1);
    idle_check(0);

    // Empty FIFO with enable high, then enable low with data waiting
    quiet_cycles(0, 100);
    en0 = 1'b0;
    push(0, 8'h96);
    quiet_cycles(0, 100);
    en0 = 1'b1;
    send_check(0, 8'h96, -1);
    idle_check(0);

    // Even parity with two stop bits: 0x07 has odd weight, parity bit 1
    push(1, 8'h07);
    en1 = 1'b1;
    send_check(1, 8'h07, -1);
    idle_check(1);
    check("cnt1_after_parity", cnt1, 16'd1);

    // Asynchronous reset in the middle of data bit 3 (0x35: bit 3 is 0)
    push(0, 8'h35);
    repeat (20) @(negedge clk);
    check("pre_rst_tx", tx0, 1'b0);
    check("pre_rst_busy", busy0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", tx0, 1'b1);
    check("async_rst_busy", busy0, 1'b0);
    check("async_rst_done", done0, 1'b0);
    check("async_rst_cnt0", cnt0, 16'h0000);
    check("async_rst_cnt1", cnt1, 16'h0000);
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    @(negedge clk);
    check("rst_hold_tx", tx0, 1'b1);
    check("rst_hold_done", done0, 1'b0);
    rst = 1'b0;
    push(0, 8'h5A);
    send_check(0, 8'h5A, -1);
    idle_check(0);

    // Drop enable during DATA: frame completes, the second byte stays queued
    push(0, 8'h81);
    push(0, 8'h42);
    send_check(0, 8'h81, 8);
    idle_check(0);
    quiet_cycles(0, 20);

    // Counter wrap
    force dut0.r_byte_cnt = 16'hFFFF;
    #1;
    release dut0.r_byte_cnt;
    exp_cnt[0] = 16'hFFFF;
    @(negedge clk);
    check("cnt_preset", cnt0, 16'hFFFF);
    en0 = 1'b1;
    send_check(0, 8'h42, -1);
    idle_check(0);
    check("cnt_wrapped", cnt0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
